rx_packet_deframer: RTL and testbench

RX_PACKET_DEFRAMER -- requirements
Module: rx_packet_deframer

---
 rtl/laserdrop_pkg.sv | 23 ++
 rtl/counter.sv | 33 +++
 rtl/rx_packet_deframer.sv | 167 ++++++++++++++++
 tb/tb_rx_packet_deframer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/laserdrop_pkg.sv
// Shared constants and types for the laser-drop receive path.
// Frame: C1 C2 C3 C4, LEN_HI, LEN_LO, LEN payload bytes, CHK (XOR of length and payload).
package laserdrop_pkg;

    localparam logic [31:0] START_SEQ = 32'hC1C2C3C4;

    localparam int unsigned LenWidth             = 11;
    localparam int unsigned TmoCntWidth          = 12;
    localparam int unsigned MaxLenDefault        = 1024;
    localparam int unsigned TimeoutCyclesDefault = 1024;

    typedef enum logic [2:0] {
        StHunt,
        StSeq1,
        StSeq2,
        StSeq3,
        StLenHi,
        StLenLo,
        StPayload,
        StCheck
    } deframer_state_e;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; clear has priority over increment.
module counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rx_packet_deframer.sv
// Hunts for the start sequence, validates length and checksum, and streams payload
// bytes straight into the FTDI write queue with zero latency.
module rx_packet_deframer
    import laserdrop_pkg::*;
#(
    parameter int unsigned MAX_LEN        = MaxLenDefault,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                data_valid,
    input  logic [7:0]          data_in,
    input  logic                wrq_full,
    output logic                wrreq,
    output logic [7:0]          data_wr,
    output logic                pkt_done,
    output logic                pkt_fail,
    output logic                busy,
    output logic [LenWidth-1:0] pkt_len
);

    localparam logic [7:0] SeqC1 = START_SEQ[31:24];
    localparam logic [7:0] SeqC2 = START_SEQ[23:16];
    localparam logic [7:0] SeqC3 = START_SEQ[15:8];
    localparam logic [7:0] SeqC4 = START_SEQ[7:0];
    localparam logic [TmoCntWidth-1:0] TimeoutCnt = TmoCntWidth'(TIMEOUT_CYCLES);

    deframer_state_e     state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [LenWidth-1:0] pkt_len_q, pkt_len_d;
    logic [LenWidth-1:0] pay_cnt_q, pay_cnt_d;
    logic [7:0]          xor_q, xor_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;

    logic [TmoCntWidth-1:0] tmo_cnt;
    logic                   tmo_clear;
    logic                   timeout_hit;
    logic [15:0]            len16;
    logic [LenWidth-1:0]    byte_n;

    // Any strobe restarts the idle window, even one that is about to expire.
    assign tmo_clear   = !en || data_valid || (state_q == StHunt);
    assign timeout_hit = (state_q != StHunt) && (tmo_cnt == TimeoutCnt) && !data_valid;

    counter #(
        .WIDTH(TmoCntWidth)
    ) u_tmo_cnt (
        .clock(clock),
        .reset(reset),
        .clear(tmo_clear),
        .inc  (!tmo_clear),
        .count(tmo_cnt)
    );

    assign len16  = {len_hi_q, data_in};
    assign byte_n = pay_cnt_q + LenWidth'(1);

    // Gated by reset so a frame interrupted by reset writes nothing more.
    assign wrreq   = (state_q == StPayload) && data_valid && en && !wrq_full && !reset;
    assign data_wr = wrreq ? data_in : 8'h00;

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        pkt_len_d = pkt_len_q;
        pay_cnt_d = pay_cnt_q;
        xor_d     = xor_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        fail_d    = 1'b0;

        if (!en) begin
            state_d  = StHunt;
            len_hi_d = 8'h00;
        end else if (timeout_hit) begin
            state_d = StHunt;
            fail_d  = 1'b1;
        end else if (data_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (data_in == SeqC1) state_d = StSeq1;
                end
                StSeq1: begin
                    if (data_in == SeqC2)      state_d = StSeq2;
                    else if (data_in == SeqC1) state_d = StSeq1;
                    else                       state_d = StHunt;
                end
                StSeq2: begin
                    if (data_in == SeqC3)      state_d = StSeq3;
                    else if (data_in == SeqC1) state_d = StSeq1;
                    else                       state_d = StHunt;
                end
                StSeq3: begin
                    if (data_in == SeqC4)      state_d = StLenHi;
                    else if (data_in == SeqC1) state_d = StSeq1;
                    else                       state_d = StHunt;
                end
                StLenHi: begin
                    len_hi_d = data_in;
                    xor_d    = data_in;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    xor_d = xor_q ^ data_in;
                    if ((len16 != 16'h0000) && (32'(len16) <= MAX_LEN)) begin
                        pkt_len_d = len16[LenWidth-1:0];
                        pay_cnt_d = '0;
                        ovf_d     = 1'b0;
                        state_d   = StPayload;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = StHunt;
                    end
                end
                StPayload: begin
                    xor_d     = xor_q ^ data_in;
                    pay_cnt_d = byte_n;
                    if (wrq_full) ovf_d = 1'b1;
                    if (byte_n == pkt_len_q) state_d = StCheck;
                end
                StCheck: begin
                    if ((data_in == xor_q) && !ovf_q) done_d = 1'b1;
                    else                              fail_d = 1'b1;
                    state_d = StHunt;
                end
                default: state_d = StHunt;
            endcase
        end

        if (state_d == StHunt) begin
            pay_cnt_d = '0;
            xor_d     = 8'h00;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StHunt;
            len_hi_q  <= 8'h00;
            pkt_len_q <= '0;
            pay_cnt_q <= '0;
            xor_q     <= 8'h00;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            pkt_len_q <= pkt_len_d;
            pay_cnt_q <= pay_cnt_d;
            xor_q     <= xor_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign pkt_done = done_q;
    assign pkt_fail = fail_q;
    assign busy     = (state_q != StHunt);
    assign pkt_len  = pkt_len_q;

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Self-checking bench for rx_packet_deframer: frame table plus hand-written corner sequences,
// with a write scoreboard that is popped whenever the DUT strobes wrreq.
module tb_rx_packet_deframer;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        wrq_full;
    logic        wrreq;
    logic [7:0]  data_wr;
    logic        pkt_done;
    logic        pkt_fail;
    logic        busy;
    logic [10:0] pkt_len;

    rx_packet_deframer dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .data_valid(data_valid),
        .data_in   (data_in),
        .wrq_full  (wrq_full),
        .wrreq     (wrreq),
        .data_wr   (data_wr),
        .pkt_done  (pkt_done),
        .pkt_fail  (pkt_fail),
        .busy      (busy),
        .pkt_len   (pkt_len)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic [7:0]  b [12];
        logic [11:0] full;
        int          nwr;
        logic [7:0]  wr [4];
        logic        done;
        logic        fail;
        logic [10:0] len;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         fail_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; outputs sampled on the falling edge.
    task automatic tick(input logic dv, input logic [7:0] b, input logic full);
        logic [7:0] e;
        data_valid = dv;
        data_in    = b;
        wrq_full   = full;
        @(negedge clock);
        if (wrreq) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wrreq: got data_wr=%02h, required no write (t=%0t)",
                         data_wr, $time);
            end else begin
                e = exp_q.pop_front();
                chk("data_wr", 32'(data_wr), 32'(e));
            end
        end else begin
            chk("data_wr_idle", 32'(data_wr), 32'h0);
        end
        chk("pulse_exclusive", 32'(pkt_done & pkt_fail), 32'h0);
        if (pkt_done) done_seen++;
        if (pkt_fail) fail_seen++;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        wrq_full   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_hdr(input logic [7:0] hi, input logic [7:0] lo);
        tick(1'b1, 8'hC1, 1'b0);
        tick(1'b1, 8'hC2, 1'b0);
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b1, 8'hC4, 1'b0);
        tick(1'b1, hi, 1'b0);
        tick(1'b1, lo, 1'b0);
    endtask

    initial begin
        int         d0;
        int         f0;
        logic [7:0] x;
        logic [7:0] pb;

        vecs[0] = '{n: 10, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03,
                    8'h00, 8'h00}, full: 12'h000, nwr: 3, wr: '{8'h11, 8'h22, 8'h33, 8'h00},
                    done: 1'b1, fail: 1'b0, len: 11'd3};
        vecs[1] = '{n: 10, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04,
                    8'h00, 8'h00}, full: 12'h000, nwr: 3, wr: '{8'h11, 8'h22, 8'h33, 8'h00},
                    done: 1'b0, fail: 1'b1, len: 11'd3};
        vecs[2] = '{n: 9, b: '{8'hC1, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h01, 8'h5A, 8'h5B, 8'h00,
                    8'h00, 8'h00}, full: 12'h000, nwr: 1, wr: '{8'h5A, 8'h00, 8'h00, 8'h00},
                    done: 1'b1, fail: 1'b0, len: 11'd1};
        // Rejected length leaves pkt_len from the previous frame.
        vecs[3] = '{n: 6, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00}, full: 12'h000, nwr: 0, wr: '{8'h00, 8'h00, 8'h00, 8'h00},
                    done: 1'b0, fail: 1'b1, len: 11'd1};
        vecs[4] = '{n: 10, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03,
                    8'h00, 8'h00}, full: 12'h080, nwr: 2, wr: '{8'h11, 8'h33, 8'h00, 8'h00},
                    done: 1'b0, fail: 1'b1, len: 11'd3};
        vecs[5] = '{n: 6, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00}, full: 12'h000, nwr: 0, wr: '{8'h00, 8'h00, 8'h00, 8'h00},
                    done: 1'b0, fail: 1'b1, len: 11'd3};
        vecs[6] = '{n: 11, b: '{8'hC1, 8'hC2, 8'h77, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h01, 8'h80,
                    8'h81, 8'h00}, full: 12'h000, nwr: 1, wr: '{8'h80, 8'h00, 8'h00, 8'h00},
                    done: 1'b1, fail: 1'b0, len: 11'd1};
        vecs[7] = '{n: 12, b: '{8'hC1, 8'hC2, 8'hC3, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h02, 8'h01,
                    8'h02, 8'h01}, full: 12'h000, nwr: 2, wr: '{8'h01, 8'h02, 8'h00, 8'h00},
                    done: 1'b1, fail: 1'b0, len: 11'd2};

        reset      = 1'b1;
        en         = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        wrq_full   = 1'b0;
        @(posedge clock);
        #1;
        idle(2);
        chk("rst_wrreq", 32'(wrreq), 32'h0);
        chk("rst_data_wr", 32'(data_wr), 32'h0);
        chk("rst_pkt_done", 32'(pkt_done), 32'h0);
        chk("rst_pkt_fail", 32'(pkt_fail), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pkt_len", 32'(pkt_len), 32'h0);
        reset = 1'b0;
        idle(1);

        for (int v = 0; v < 8; v++) begin
            d0 = done_seen;
            f0 = fail_seen;
            for (int k = 0; k < vecs[v].nwr; k++) exp_q.push_back(vecs[v].wr[k]);
            for (int i = 0; i < vecs[v].n; i++) tick(1'b1, vecs[v].b[i], vecs[v].full[i]);
            chk($sformatf("v%0d_done_timing", v), 32'(pkt_done), 32'(vecs[v].done));
            chk($sformatf("v%0d_fail_timing", v), 32'(pkt_fail), 32'(vecs[v].fail));
            idle(3);
            chk($sformatf("v%0d_done_count", v), 32'(done_seen - d0), 32'(vecs[v].done));
            chk($sformatf("v%0d_fail_count", v), 32'(fail_seen - f0), 32'(vecs[v].fail));
            chk($sformatf("v%0d_writes_missing", v), 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            chk($sformatf("v%0d_pkt_len", v), 32'(pkt_len), 32'(vecs[v].len));
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
        end

        // Largest legal length: 1024 payload bytes, pkt_len must hold 0x400.
        d0 = done_seen;
        f0 = fail_seen;
        x  = 8'h04;
        send_hdr(8'h04, 8'h00);
        chk("max_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 1024; i++) begin
            pb = 8'(i * 7 + 3);
            x  = x ^ pb;
            exp_q.push_back(pb);
            tick(1'b1, pb, 1'b0);
        end
        tick(1'b1, x, 1'b0);
        chk("max_done_timing", 32'(pkt_done), 32'h1);
        idle(3);
        chk("max_done_count", 32'(done_seen - d0), 32'h1);
        chk("max_fail_count", 32'(fail_seen - f0), 32'h0);
        chk("max_writes_missing", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        chk("max_pkt_len", 32'(pkt_len), 32'h400);

        // Stall mid-frame: no abort while count is still climbing to the limit.
        f0 = fail_seen;
        send_hdr(8'h00, 8'h05);
        idle(1024);
        chk("tmo_no_early_fail", 32'(pkt_fail), 32'h0);
        chk("tmo_busy_before", 32'(busy), 32'h1);
        idle(1);
        chk("tmo_fail_pulse", 32'(pkt_fail), 32'h1);
        chk("tmo_busy_after", 32'(busy), 32'h0);
        idle(2);
        chk("tmo_fail_count", 32'(fail_seen - f0), 32'h1);

        // Byte arriving at the terminal count is processed instead of timing out.
        d0 = done_seen;
        f0 = fail_seen;
        send_hdr(8'h00, 8'h01);
        idle(1024);
        exp_q.push_back(8'h7E);
        tick(1'b1, 8'h7E, 1'b0);
        chk("tmo_race_no_fail", 32'(pkt_fail), 32'h0);
        chk("tmo_race_busy", 32'(busy), 32'h1);
        tick(1'b1, 8'h7F, 1'b0);
        chk("tmo_race_done", 32'(pkt_done), 32'h1);
        idle(2);
        chk("tmo_race_done_count", 32'(done_seen - d0), 32'h1);
        chk("tmo_race_fail_count", 32'(fail_seen - f0), 32'h0);
        chk("tmo_race_writes", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Enable dropped mid-payload: silent abandon, then a clean frame decodes.
        d0 = done_seen;
        f0 = fail_seen;
        send_hdr(8'h00, 8'h02);
        exp_q.push_back(8'h01);
        tick(1'b1, 8'h01, 1'b0);
        en = 1'b0;
        tick(1'b1, 8'h02, 1'b0);
        chk("en_low_busy", 32'(busy), 32'h0);
        en = 1'b1;
        idle(2);
        send_hdr(8'h00, 8'h01);
        exp_q.push_back(8'hAB);
        tick(1'b1, 8'hAB, 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        idle(2);
        chk("en_low_done_count", 32'(done_seen - d0), 32'h1);
        chk("en_low_fail_count", 32'(fail_seen - f0), 32'h0);
        chk("en_low_writes", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Reset mid-payload: the byte under reset is not written and no pulse follows.
        d0 = done_seen;
        f0 = fail_seen;
        send_hdr(8'h00, 8'h03);
        exp_q.push_back(8'h11);
        tick(1'b1, 8'h11, 1'b0);
        chk("rst_mid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1'b1, 8'h22, 1'b0);
        reset = 1'b0;
        idle(3);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_pkt_len", 32'(pkt_len), 32'h0);
        chk("rst_mid_done_count", 32'(done_seen - d0), 32'h0);
        chk("rst_mid_fail_count", 32'(fail_seen - f0), 32'h0);
        chk("rst_mid_writes", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
